alu_bist_ctrl: RTL and testbench



---
 rtl/alu_bist_pkg.sv | 28 ++
 rtl/alu_bist_misr.sv | 31 +++
 rtl/alu_bist_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_alu_bist_ctrl.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// Shared types and helpers for the ALU built-in self-test controller:
// FSM state encoding, MISR polynomial/seed and the MISR step function.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DONE  = 2'd3
  } bist_state_e;

  localparam logic [15:0] MISR_POLY    = 16'h1021;
  localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;
  localparam int unsigned DEF_WIDTH    = 4;
  localparam int unsigned DEF_OP_W     = 3;

  // Captured vector is {s, A, B, Y}.
  function automatic int unsigned res_w(input int unsigned width, input int unsigned op_w);
    return op_w + 3 * width;
  endfunction

  localparam int unsigned RES_W = res_w(DEF_WIDTH, DEF_OP_W);

  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
    return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ din;
  endfunction

endpackage

// File: rtl/alu_bist_misr.sv
// 16-bit multiple-input signature register; load has priority over en.
module alu_bist_misr
  import alu_bist_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        en,
  input  logic [15:0] din,
  output logic [15:0] sig
);

  logic [15:0] sig_r;

  // Signature register: seed on reset/load, one fold per enabled edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_r <= seed;
    end else if (load) begin
      sig_r <= seed;
    end else if (en) begin
      sig_r <= misr_step(sig_r, din);
    end else begin
      sig_r <= sig_r;
    end
  end

  assign sig = sig_r;

endmodule

// File: rtl/alu_bist_ctrl.sv
// Self-test sequencer for the 4-bit ALU: walks every enabled op over all
// operand pairs, streams {s,A,B,Y} over valid/ready and signs Y into a MISR.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int unsigned          WIDTH    = 4,
  parameter int unsigned          OP_W     = 3,
  parameter logic [(2**OP_W)-1:0] OP_MASK  = 8'hFF,
  parameter int unsigned          SETTLE   = 1,
  parameter logic [15:0]          SIG_SEED = DEFAULT_SEED
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                exp_sig,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [OP_W-1:0]            alu_s,
  input  logic [WIDTH-1:0]           alu_y,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OP_W+3*WIDTH-1:0]    res_data,
  output logic                       busy,
  output logic                       done,
  output logic                       pass,
  output logic [15:0]                signature
);

  localparam int unsigned NUM_OPS = 2**OP_W;
  localparam int unsigned DATA_W  = res_w(WIDTH, OP_W);
  localparam int unsigned CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [WIDTH-1:0]  OPND_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]  OPND_ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0]  OPND_MAX  = {WIDTH{1'b1}};
  localparam logic [OP_W-1:0]   OP_ZERO   = {OP_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  bist_state_e       state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [WIDTH-1:0]  a_r, a_s, b_r, b_s;
  logic [OP_W-1:0]   s_r, s_s;
  logic [DATA_W-1:0] data_r, data_s;
  logic              valid_r, valid_s, busy_r, busy_s, done_r, done_s, pass_r, pass_s;
  logic              misr_load_s, misr_en_s;
  logic [OP_W-1:0]   first_op_s, next_op_s;
  logic              has_first_s, has_next_s;

  // Lowest enabled op, and the next enabled op above the current one.
  always_comb begin
    first_op_s  = OP_ZERO;
    has_first_s = 1'b0;
    next_op_s   = OP_ZERO;
    has_next_s  = 1'b0;
    for (int k = NUM_OPS - 1; k >= 0; k--) begin
      if (OP_MASK[k]) begin
        first_op_s  = OP_W'(k);
        has_first_s = 1'b1;
      end else begin
        has_first_s = has_first_s;
      end
      if (OP_MASK[k] && (k > int'(s_r))) begin
        next_op_s  = OP_W'(k);
        has_next_s = 1'b1;
      end else begin
        has_next_s = has_next_s;
      end
    end
  end

  // Next-state and next-output logic for the sweep FSM.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    a_s         = a_r;
    b_s         = b_r;
    s_s         = s_r;
    data_s      = data_r;
    valid_s     = valid_r;
    busy_s      = busy_r;
    done_s      = done_r;
    pass_s      = pass_r;
    misr_load_s = 1'b0;
    misr_en_s   = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          misr_load_s = 1'b1;
          a_s         = OPND_ZERO;
          b_s         = OPND_ZERO;
          cnt_s       = CNT_ZERO;
          if (has_first_s) begin
            s_s     = first_op_s;
            busy_s  = 1'b1;
            done_s  = 1'b0;
            pass_s  = 1'b0;
            state_s = ST_DRIVE;
          end else begin
            // Nothing to sweep: finish immediately on the seed value.
            s_s     = OP_ZERO;
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (SIG_SEED == exp_sig);
            state_s = ST_DONE;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_DRIVE: begin
        if (cnt_r == CNT_LAST) begin
          data_s    = {s_r, a_r, b_r, alu_y};
          valid_s   = 1'b1;
          misr_en_s = 1'b1;
          cnt_s     = CNT_ZERO;
          state_s   = ST_HOLD;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          valid_s = 1'b0;
          state_s = ST_DRIVE;
          if (b_r != OPND_MAX) begin
            b_s = b_r + OPND_ONE;
          end else if (a_r != OPND_MAX) begin
            a_s = a_r + OPND_ONE;
            b_s = OPND_ZERO;
          end else if (has_next_s) begin
            s_s = next_op_s;
            a_s = OPND_ZERO;
            b_s = OPND_ZERO;
          end else begin
            busy_s  = 1'b0;
            done_s  = 1'b1;
            pass_s  = (signature == exp_sig);
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      a_r     <= OPND_ZERO;
      b_r     <= OPND_ZERO;
      s_r     <= OP_ZERO;
      data_r  <= DATA_ZERO;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      a_r     <= a_s;
      b_r     <= b_s;
      s_r     <= s_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      pass_r  <= pass_s;
    end
  end

  alu_bist_misr u_misr (
    .clk  (clk),
    .rst  (rst),
    .load (misr_load_s),
    .seed (SIG_SEED),
    .en   (misr_en_s),
    .din  (16'(alu_y)),
    .sig  (signature)
  );

  assign alu_a     = a_r;
  assign alu_b     = b_r;
  assign alu_s     = s_r;
  assign res_data  = data_r;
  assign res_valid = valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: three instances (mask 01, mask 84 with SETTLE=2,
// empty mask) driven against a stub ALU and a vector/signature model.
module tb_alu_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int checks = 0;
  int errors = 0;

  logic [14:0] exp_q[$];
  logic [15:0] model_sig;

  function automatic logic [3:0] stub_y(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return {a[2:0], 1'b0};
      default: return b ^ 4'h5;
    endcase
  endfunction

  // Expected vector stream and final signature for a mask, straight from the sweep rules.
  task automatic build_model(input logic [7:0] mask);
    int sig;
    logic [3:0] y;
    exp_q.delete();
    sig = 'hFFFF;
    for (int op = 0; op < 8; op++) begin
      if (mask[op]) begin
        for (int a = 0; a < 16; a++) begin
          for (int b = 0; b < 16; b++) begin
            y = stub_y(3'(op), 4'(a), 4'(b));
            exp_q.push_back({3'(op), 4'(a), 4'(b), y});
            sig = ((sig * 2) % 65536) ^ ((sig >= 32768) ? 'h1021 : 0) ^ int'(y);
          end
        end
      end
    end
    model_sig = 16'(sig);
  endtask

  // Instance 1: op 0 only, SETTLE 1
  logic start_1, ready_1, valid_1, busy_1, done_1, pass_1;
  logic [15:0] exp_sig_1, sig_1;
  logic [3:0] a_1, b_1, y_1;
  logic [2:0] s_1;
  logic [14:0] data_1;
  assign y_1 = stub_y(s_1, a_1, b_1);

  alu_bist_ctrl #(.WIDTH(4), .OP_W(3), .OP_MASK(8'h01), .SETTLE(1), .SIG_SEED(16'hFFFF)) u_m01 (
    .clk(clk), .rst(rst), .start(start_1), .exp_sig(exp_sig_1),
    .alu_a(a_1), .alu_b(b_1), .alu_s(s_1), .alu_y(y_1),
    .res_valid(valid_1), .res_ready(ready_1), .res_data(data_1),
    .busy(busy_1), .done(done_1), .pass(pass_1), .signature(sig_1));

  // Instance 2: ops 2 and 7, SETTLE 2
  logic start_2, ready_2, valid_2, busy_2, done_2, pass_2;
  logic [15:0] exp_sig_2, sig_2;
  logic [3:0] a_2, b_2, y_2;
  logic [2:0] s_2;
  logic [14:0] data_2;
  assign y_2 = stub_y(s_2, a_2, b_2);

  alu_bist_ctrl #(.WIDTH(4), .OP_W(3), .OP_MASK(8'h84), .SETTLE(2), .SIG_SEED(16'hFFFF)) u_m84 (
    .clk(clk), .rst(rst), .start(start_2), .exp_sig(exp_sig_2),
    .alu_a(a_2), .alu_b(b_2), .alu_s(s_2), .alu_y(y_2),
    .res_valid(valid_2), .res_ready(ready_2), .res_data(data_2),
    .busy(busy_2), .done(done_2), .pass(pass_2), .signature(sig_2));

  // Instance 0: empty mask
  logic start_0, ready_0, valid_0, busy_0, done_0, pass_0;
  logic [15:0] exp_sig_0, sig_0;
  logic [3:0] a_0, b_0, y_0;
  logic [2:0] s_0;
  logic [14:0] data_0;
  assign y_0 = stub_y(s_0, a_0, b_0);

  alu_bist_ctrl #(.WIDTH(4), .OP_W(3), .OP_MASK(8'h00), .SETTLE(1), .SIG_SEED(16'hFFFF)) u_m00 (
    .clk(clk), .rst(rst), .start(start_0), .exp_sig(exp_sig_0),
    .alu_a(a_0), .alu_b(b_0), .alu_s(s_0), .alu_y(y_0),
    .res_valid(valid_0), .res_ready(ready_0), .res_data(data_0),
    .busy(busy_0), .done(done_0), .pass(pass_0), .signature(sig_0));

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({a_1, b_1, s_1} !== 11'h000) begin
      errors++; $display("FAIL reset_operands got %h want 000", {a_1, b_1, s_1});
    end
    checks++;
    if ({valid_1, busy_1, done_1, pass_1} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {valid_1, busy_1, done_1, pass_1});
    end
    checks++;
    if (data_1 !== 15'h0000) begin
      errors++; $display("FAIL reset_data got %h want 0000", data_1);
    end
    checks++;
    if (sig_1 !== 16'hFFFF || sig_2 !== 16'hFFFF) begin
      errors++; $display("FAIL reset_signature got %h/%h want ffff", sig_1, sig_2);
    end
  endtask

  task automatic test_misr_step();
    ready_1 = 1'b0;
    @(negedge clk); start_1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start_1 = 1'b0;
    checks++;
    if ({a_1, b_1, s_1, busy_1, valid_1} !== 13'b0000_0000_000_1_0) begin
      errors++; $display("FAIL start_state got a=%h b=%h s=%h busy=%b valid=%b want 0 0 0 1 0", a_1, b_1, s_1, busy_1, valid_1);
    end
    @(negedge clk);
    checks++;
    if (valid_1 !== 1'b1 || data_1 !== 15'h0000) begin
      errors++; $display("FAIL first_capture got valid=%b data=%h want 1 0000", valid_1, data_1);
    end
    checks++;
    if (sig_1 !== 16'hEFDF) begin
      errors++; $display("FAIL misr_step got %h want efdf", sig_1);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_sweep();
    int n, idx, done_at;
    logic [14:0] first_d, last_d;
    build_model(8'h01);
    exp_sig_1 = model_sig;
    ready_1 = 1'b1;
    first_d = 15'h7FFF; last_d = 15'h7FFF;
    @(negedge clk); start_1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start_1 = 1'b0;
    n = 0; idx = 0; done_at = -1;
    while (n <= 2000 && done_at < 0) begin
      if (valid_1 && ready_1) begin
        checks++;
        if (idx >= exp_q.size() || data_1 !== exp_q[idx]) begin
          errors++; $display("FAIL sweep_data[%0d] got %h want %h", idx, data_1, (idx < exp_q.size()) ? exp_q[idx] : 15'h7FFF);
        end
        if (idx == 0) first_d = data_1;
        last_d = data_1;
        idx++;
      end
      if (done_1) done_at = n;
      else begin @(negedge clk); n++; end
    end
    checks++;
    if (done_at != 512) begin
      errors++; $display("FAIL done_cycle got %0d want 512", done_at);
    end
    checks++;
    if (idx != 256) begin
      errors++; $display("FAIL transfer_count got %0d want 256", idx);
    end
    checks++;
    if (first_d !== 15'h0000 || last_d !== 15'h0FFE) begin
      errors++; $display("FAIL first_last got %h/%h want 0000/0ffe", first_d, last_d);
    end
    checks++;
    if (pass_1 !== 1'b1 || busy_1 !== 1'b0 || sig_1 !== model_sig) begin
      errors++; $display("FAIL sweep_result got pass=%b busy=%b sig=%h want 1 0 %h", pass_1, busy_1, sig_1, model_sig);
    end
  endtask

  task automatic test_backpressure();
    int n, idx, stall;
    logic [14:0] held_d;
    logic [10:0] held_op;
    build_model(8'h01);
    exp_sig_1 = model_sig;
    ready_1 = 1'b1;
    @(negedge clk); start_1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start_1 = 1'b0;
    n = 0; idx = 0; stall = 0; held_d = 15'h0; held_op = 11'h0;
    while (n <= 4000 && !done_1) begin
      if (valid_1 && idx == 3) begin
        if (stall == 0) begin
          held_d = data_1; held_op = {a_1, b_1, s_1};
        end else begin
          checks++;
          if (data_1 !== held_d || {a_1, b_1, s_1} !== held_op) begin
            errors++; $display("FAIL stall_hold[%0d] got %h/%h want %h/%h", stall, data_1, {a_1, b_1, s_1}, held_d, held_op);
          end
        end
        if (stall < 5) begin ready_1 = 1'b0; stall++; end
        else ready_1 = 1'b1;
      end else begin
        ready_1 = (idx <= 3) ? 1'b1 : ($urandom_range(3, 0) != 0);
      end
      if (valid_1 && ready_1) begin
        checks++;
        if (idx >= exp_q.size() || data_1 !== exp_q[idx]) begin
          errors++; $display("FAIL bp_data[%0d] got %h want %h", idx, data_1, (idx < exp_q.size()) ? exp_q[idx] : 15'h7FFF);
        end
        idx++;
      end
      @(negedge clk); n++;
    end
    ready_1 = 1'b1;
    checks++;
    if (stall != 5 || idx != 256) begin
      errors++; $display("FAIL bp_counts got stall=%0d xfers=%0d want 5 256", stall, idx);
    end
    checks++;
    if (done_1 !== 1'b1 || pass_1 !== 1'b1 || sig_1 !== model_sig) begin
      errors++; $display("FAIL bp_signature got done=%b pass=%b sig=%h want 1 1 %h", done_1, pass_1, sig_1, model_sig);
    end
  endtask

  task automatic test_op_mask();
    int n, idx;
    build_model(8'h84);
    exp_sig_2 = model_sig;
    ready_2 = 1'b1;
    @(negedge clk); start_2 = 1'b1;
    @(posedge clk);
    @(negedge clk); start_2 = 1'b0;
    n = 0; idx = 0;
    while (n <= 6000 && !done_2) begin
      ready_2 = ($urandom_range(2, 0) != 0);
      if (valid_2 && ready_2) begin
        checks++;
        if (idx >= exp_q.size() || data_2 !== exp_q[idx] || (data_2[14:12] != 3'd2 && data_2[14:12] != 3'd7)) begin
          errors++; $display("FAIL mask_data[%0d] got %h want %h", idx, data_2, (idx < exp_q.size()) ? exp_q[idx] : 15'h7FFF);
        end
        idx++;
      end
      @(negedge clk); n++;
    end
    checks++;
    if (idx != 512) begin
      errors++; $display("FAIL mask_count got %0d want 512", idx);
    end
    checks++;
    if (done_2 !== 1'b1 || pass_2 !== 1'b1 || sig_2 !== model_sig) begin
      errors++; $display("FAIL mask_signature got done=%b pass=%b sig=%h want 1 1 %h", done_2, pass_2, sig_2, model_sig);
    end
  endtask

  task automatic test_reset_restart();
    int n, idx, pulses;
    logic seen_valid;
    build_model(8'h01);
    exp_sig_1 = model_sig;
    ready_1 = 1'b1;
    @(negedge clk); start_1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start_1 = 1'b0;
    n = 0; idx = 0;
    while (n <= 1000 && !(valid_1 && idx == 100)) begin
      if (valid_1) idx++;
      @(negedge clk); n++;
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if ({a_1, b_1, s_1, valid_1, busy_1, done_1, pass_1, data_1, sig_1} !== {11'h000, 4'b0000, 15'h0000, 16'hFFFF}) begin
      errors++; $display("FAIL midsweep_reset got a=%h b=%h s=%h v=%b busy=%b done=%b pass=%b data=%h sig=%h", a_1, b_1, s_1, valid_1, busy_1, done_1, pass_1, data_1, sig_1);
    end
    seen_valid = 1'b0;
    repeat (10) begin @(negedge clk); seen_valid = seen_valid | valid_1; end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_valid got %b want 0", seen_valid);
    end
    @(negedge clk); start_1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start_1 = 1'b0;
    n = 0; idx = 0; pulses = 0;
    while (n <= 2000 && !done_1) begin
      start_1 = 1'b0;
      if ((idx == 5 && pulses == 0) || (idx == 200 && pulses == 1)) begin
        start_1 = 1'b1; pulses++;
      end
      if (valid_1 && ready_1) begin
        checks++;
        if (idx >= exp_q.size() || data_1 !== exp_q[idx]) begin
          errors++; $display("FAIL restart_data[%0d] got %h want %h", idx, data_1, (idx < exp_q.size()) ? exp_q[idx] : 15'h7FFF);
        end
        idx++;
      end
      @(negedge clk); n++;
    end
    start_1 = 1'b0;
    checks++;
    if (idx != 256 || pulses != 2 || pass_1 !== 1'b1 || sig_1 !== model_sig) begin
      errors++; $display("FAIL restart_result got xfers=%0d pulses=%0d pass=%b sig=%h want 256 2 1 %h", idx, pulses, pass_1, sig_1, model_sig);
    end
  endtask

  task automatic test_empty_mask();
    logic seen_valid;
    ready_0 = 1'b1;
    exp_sig_0 = 16'h1234;
    @(negedge clk); start_0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start_0 = 1'b0;
    checks++;
    if ({done_0, busy_0, pass_0, valid_0} !== 4'b1000 || sig_0 !== 16'hFFFF) begin
      errors++; $display("FAIL empty_done got done=%b busy=%b pass=%b valid=%b sig=%h want 1 0 0 0 ffff", done_0, busy_0, pass_0, valid_0, sig_0);
    end
    seen_valid = 1'b0;
    repeat (8) begin @(negedge clk); seen_valid = seen_valid | valid_0; end
    checks++;
    if (seen_valid !== 1'b0) begin
      errors++; $display("FAIL empty_transfers got %b want 0", seen_valid);
    end
    exp_sig_0 = 16'hFFFF;
    start_0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start_0 = 1'b0;
    checks++;
    if (done_0 !== 1'b1 || pass_0 !== 1'b1) begin
      errors++; $display("FAIL empty_pass got done=%b pass=%b want 1 1", done_0, pass_0);
    end
  endtask

  initial begin
    rst = 1'b1;
    start_1 = 1'b0; start_2 = 1'b0; start_0 = 1'b0;
    ready_1 = 1'b0; ready_2 = 1'b0; ready_0 = 1'b0;
    exp_sig_1 = 16'h0000; exp_sig_2 = 16'h0000; exp_sig_0 = 16'h0000;
    test_reset();
    test_misr_step();
    test_single_sweep();
    test_backpressure();
    test_op_mask();
    test_reset_restart();
    test_empty_mask();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
